// File: rtl/dict_value_prog_compressor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dict_value_prog_compressor: serial chunker -> programmable codebook -> FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
module dict_value_prog_compressor #(
  parameter int CHUNK_SIZE = 4,
  parameter int INDEX_BITS = 3,
  parameter int NUM_CHUNKS = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  flush,
  input  logic                  cfg_we,
  input  logic [CHUNK_SIZE-1:0] cfg_addr,
  input  logic [INDEX_BITS-1:0] cfg_data,
  output logic [INDEX_BITS-1:0] out_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  busy
);
  localparam int ENTRIES = 1 << CHUNK_SIZE;
  localparam int BCW     = $clog2(CHUNK_SIZE + 1);
  localparam int CCW     = $clog2(NUM_CHUNKS + 1);
  localparam int PW      = $clog2(FIFO_DEPTH);

  localparam logic [BCW-1:0] FULL_COUNT = BCW'(CHUNK_SIZE);
  localparam logic [CCW-1:0] FRAME_LEN  = CCW'(NUM_CHUNKS);
  localparam logic [PW:0]    FIFO_CAP   = (PW+1)'(FIFO_DEPTH);

  function automatic logic [INDEX_BITS-1:0] default_entry(input int k);
    int ones;
    ones = 0;
    for (int b = 0; b < CHUNK_SIZE; b++) ones += (k >> b) & 1;
    if (ones > (1 << INDEX_BITS) - 1) ones = (1 << INDEX_BITS) - 1;
    return INDEX_BITS'(ones);
  endfunction

  logic [INDEX_BITS-1:0] codebook [ENTRIES];
  logic [INDEX_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [CHUNK_SIZE-1:0] chunk_reg;
  logic [CHUNK_SIZE-1:0] shifted;
  logic [CHUNK_SIZE-1:0] key;
  logic [BCW-1:0]        bit_count;
  logic [BCW-1:0]        filled;
  logic [CCW-1:0]        chunk_cnt;
  logic [CCW-1:0]        cnt_next;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           occupancy;
  logic                  accept;
  logic                  flush_ok;
  logic                  push;
  logic                  pop;
  logic                  frame_end;

  assign data_ready = occupancy < FIFO_CAP;
  assign out_valid  = occupancy != '0;
  assign out_index  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign busy       = (bit_count != '0) || out_valid;

  // The left shift aligns a partial chunk and discards stale upper bits;
  // for a complete chunk the shift amount is zero.
  always_comb begin
    accept    = data_valid && data_ready;
    flush_ok  = flush && data_ready;
    shifted   = accept ? {chunk_reg[CHUNK_SIZE-2:0], data_in} : chunk_reg;
    filled    = bit_count + BCW'(accept);
    key       = shifted << (FULL_COUNT - filled);
    push      = (filled == FULL_COUNT) || (flush_ok && (filled != '0));
    pop       = out_valid && out_ready;
    cnt_next  = chunk_cnt + CCW'(push);
    frame_end = (push && (cnt_next == FRAME_LEN)) || (flush_ok && (cnt_next != '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ENTRIES; k++) codebook[k] <= default_entry(k);
    end else if (cfg_we) begin
      codebook[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chunk_reg  <= '0;
      bit_count  <= '0;
      chunk_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      chunk_reg  <= shifted;
      bit_count  <= push ? '0 : filled;
      chunk_cnt  <= frame_end ? '0 : cnt_next;
      frame_done <= frame_end;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      occupancy <= occupancy + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Lookup reads the registered codebook, so a same-edge write is not seen.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= codebook[key];
  end

endmodule
`default_nettype wire

// File: tb/tb_dict_value_prog_compressor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dict_value_prog_compressor: directed self-checking bench
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_dict_value_prog_compressor;
  localparam int CS = 4;
  localparam int IB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_in;
  logic          data_valid;
  logic          data_ready;
  logic          flush;
  logic          cfg_we;
  logic [CS-1:0] cfg_addr;
  logic [IB-1:0] cfg_data;
  logic [IB-1:0] out_index;
  logic          out_valid;
  logic          out_ready;
  logic          frame_done;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int frames = 0;
  logic [IB-1:0] popq[$];

  always #5 clk = ~clk;

  dict_value_prog_compressor #(
    .CHUNK_SIZE(CS), .INDEX_BITS(IB), .NUM_CHUNKS(32), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .flush(flush), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .out_index(out_index),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done),
    .busy(busy)
  );

  // Record popped indices and frame pulses
  always @(negedge clk) begin
    if (out_valid && out_ready) popq.push_back(out_index);
    if (frame_done) frames++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; data_valid = 1'b0; flush = 1'b0; cfg_we = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int guard;
    guard = 0;
    data_in = b;
    data_valid = 1'b1;
    while (!data_ready && guard < 200) begin
      tick;
      guard++;
    end
    if (!data_ready) check("send_timeout", 32'(data_ready), 1);
    tick;
    data_valid = 1'b0;
  endtask

  task automatic send_chunk(input logic [CS-1:0] c);
    for (int i = CS - 1; i >= 0; i--) send_bit(c[i]);
  endtask

  task automatic do_flush;
    int guard;
    guard = 0;
    flush = 1'b1;
    while (!data_ready && guard < 200) begin
      tick;
      guard++;
    end
    if (!data_ready) check("flush_timeout", 32'(data_ready), 1);
    tick;
    flush = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int f0;
    int bad;
    rst = 1'b1; data_in = 1'b0; data_valid = 1'b0; flush = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; out_ready = 1'b0;

    // Reset values
    tick;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_index", 32'(out_index), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data_ready", 32'(data_ready), 1);
    tick;
    rst = 1'b0;

    // Default codebook: 1011 -> popcount 3
    out_ready = 1'b1;
    send_chunk(4'b1011);
    check("dflt_valid", 32'(out_valid), 1);
    check("dflt_index", 32'(out_index), 3);
    check("dflt_busy", 32'(busy), 1);
    tick;
    check("dflt_popped", 32'(out_valid), 0);

    // Programmed entry
    cfg_we = 1'b1; cfg_addr = 4'b1011; cfg_data = 3'd7;
    tick;
    cfg_we = 1'b0;
    send_chunk(4'b1011);
    check("prog_index", 32'(out_index), 7);

    // Same-edge write and lookup uses old value
    do_reset;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    data_in = 1'b1; data_valid = 1'b1;
    cfg_we = 1'b1; cfg_addr = 4'b1011; cfg_data = 3'd7;
    tick;
    data_valid = 1'b0; cfg_we = 1'b0;
    check("same_edge_old", 32'(out_index), 3);
    tick;
    send_chunk(4'b1011);
    check("same_edge_written", 32'(out_index), 7);

    // Partial flush: 11 -> 1100 -> 2, one frame pulse
    do_reset;
    f0 = frames;
    send_bit(1'b1); send_bit(1'b1);
    check("partial_busy", 32'(busy), 1);
    do_flush;
    check("flush_valid", 32'(out_valid), 1);
    check("flush_index", 32'(out_index), 2);
    check("flush_frame", 32'(frame_done), 1);
    tick;
    check("flush_frame_pulse", 32'(frame_done), 0);
    tick;
    check("flush_frame_count", 32'(frames - f0), 1);

    // Idle flush: nothing happens
    do_reset;
    f0 = frames;
    do_flush;
    check("idle_flush_valid", 32'(out_valid), 0);
    check("idle_flush_frame", 32'(frame_done), 0);
    tick;
    check("idle_flush_count", 32'(frames - f0), 0);

    // Flush on the completing bit pushes once
    do_reset;
    base = popq.size();
    f0 = frames;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    data_in = 1'b1; data_valid = 1'b1; flush = 1'b1;
    tick;
    data_valid = 1'b0; flush = 1'b0;
    check("flush_full_frame", 32'(frame_done), 1);
    check("flush_full_index", 32'(out_index), 4);
    tick;
    tick;
    check("flush_full_pushes", 32'(popq.size() - base), 1);
    check("flush_full_frames", 32'(frames - f0), 1);

    // Backpressure: codebook[k]=7-k, 9 chunks with out_ready low
    do_reset;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cfg_we = 1'b1; cfg_addr = 4'(k); cfg_data = 3'(7 - k);
      tick;
    end
    cfg_we = 1'b0;
    base = popq.size();
    f0 = frames;
    for (int k = 0; k < 8; k++) send_chunk(4'(k));
    check("full_ready", 32'(data_ready), 0);
    check("full_head", 32'(out_index), 7);
    data_in = 1'b1; data_valid = 1'b1;
    tick;
    tick;
    check("full_hold_ready", 32'(data_ready), 0);
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    for (int i = 0; i < 20; i++) tick;
    check("bp_pop_count", 32'(popq.size() - base), 9);
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (popq.size() > base + i) begin
        if (popq[base + i] !== ((i < 8) ? 3'(7 - i) : 3'd1)) bad++;
      end
    end
    check("bp_pop_order", 32'(bad), 0);
    check("bp_no_frame", 32'(frames - f0), 0);

    // 256 ones: two full frames, counter wraps
    do_reset;
    out_ready = 1'b1;
    base = popq.size();
    f0 = frames;
    for (int i = 0; i < 256; i++) begin
      send_bit(1'b1);
      if (i == 126) check("ones_no_early_frame", 32'(frames - f0), 0);
      if (i == 127) check("ones_frame1", 32'(frame_done), 1);
      if (i == 128) check("ones_frame1_pulse", 32'(frame_done), 0);
      if (i == 254) check("ones_wrap_no_early", 32'(frames - f0), 1);
      if (i == 255) check("ones_frame2", 32'(frame_done), 1);
    end
    tick;
    tick;
    check("ones_frames", 32'(frames - f0), 2);
    check("ones_pops", 32'(popq.size() - base), 64);
    bad = 0;
    for (int i = base; i < popq.size(); i++) if (popq[i] !== 3'd4) bad++;
    check("ones_values", 32'(bad), 0);

    // Mid-frame reset discards buffered and partial data
    do_reset;
    out_ready = 1'b0;
    f0 = frames;
    send_chunk(4'b1111); send_chunk(4'b1111); send_chunk(4'b1111);
    send_bit(1'b1); send_bit(1'b1);
    check("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_index", 32'(out_index), 0);
    base = popq.size();
    out_ready = 1'b1;
    send_chunk(4'b0000);
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_index", 32'(out_index), 0);
    tick;
    tick;
    check("post_rst_pops", 32'(popq.size() - base), 1);
    check("post_rst_frames", 32'(frames - f0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
